// File: rtl/input_cond_pkg.sv
// Shared types and default timing constants for the switch input conditioner.
package input_cond_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_DB     = 3'd1,
    HOLD         = 3'd2,
    RELEASE_WAIT = 3'd3,
    RELEASE_DB   = 3'd4
  } state_e;

  // Sized for CLOCK_50: 10 ms debounce, 120 ms stretched enter level.
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
  localparam int unsigned HOLD_CYCLES_DEF     = 6000000;
  localparam int unsigned CNT_W               = 32;

endpackage

// File: rtl/switch_input_conditioner_sync2.sv
// Two-flop synchronizer of parameterised width, async active-high reset to 0.
module sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/switch_input_conditioner.sv
// Synchronizes board switches, debounces Enter, captures data on each accepted
// press and stretches EnterOut so the divided processor clock can sample it.
module switch_input_conditioner
  import input_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int unsigned DATA_W          = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              EnterIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              EnterOut,
  output logic              Busy,
  output logic [7:0]        PressCount
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [DATA_W:0]   sync_bus;
  logic              enter_sync;
  logic [DATA_W-1:0] data_sync;

  sync2 #(
    .W(DATA_W + 1)
  ) u_sync (
    .clk (Clock),
    .rst (Reset),
    .d_i ({EnterIn, DataIn}),
    .q_o (sync_bus)
  );

  assign enter_sync = sync_bus[DATA_W];
  assign data_sync  = sync_bus[DATA_W-1:0];

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              enter_q, enter_d;
  logic [7:0]        count_q, count_d;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      enter_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      enter_q <= enter_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    enter_d = enter_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (enter_sync) state_d = PRESS_DB;
      end
      PRESS_DB: begin
        if (!enter_sync) begin
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          state_d = HOLD;
          data_d  = data_sync;
          enter_d = 1'b1;
          count_d = count_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        // Switch level is deliberately ignored until the stretch completes.
        if (cnt_q == HOLD_LAST) begin
          state_d = RELEASE_WAIT;
          enter_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (!enter_sync) state_d = RELEASE_DB;
      end
      RELEASE_DB: begin
        if (enter_sync) begin
          state_d = RELEASE_WAIT;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  assign DataOut    = data_q;
  assign EnterOut   = enter_q;
  assign Busy       = (state_q != IDLE);
  assign PressCount = count_q;

endmodule

// File: tb/tb_switch_input_conditioner.sv
// Self-checking bench for switch_input_conditioner with short debounce/hold times.
module tb_switch_input_conditioner;

  localparam int D = 4;
  localparam int H = 8;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] DataIn = 8'h00;
  logic       EnterIn = 1'b0;
  logic [7:0] DataOut;
  logic       EnterOut;
  logic       Busy;
  logic [7:0] PressCount;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  switch_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .DATA_W         (8)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .DataIn    (DataIn),
    .EnterIn   (EnterIn),
    .DataOut   (DataOut),
    .EnterOut  (EnterOut),
    .Busy      (Busy),
    .PressCount(PressCount)
  );

  // Reference model: run lengths of the synchronized Enter level decide
  // acceptance (D+1 consecutive highs while armed) and re-arming (D+1 lows).
  typedef enum {M_ARMED, M_HOLDING, M_RELEASING} mphase_e;
  mphase_e    ph = M_ARMED;
  int         ones = 0, zeros = 0, hold_left = 0;
  logic       e1 = 0, e2 = 0;
  logic [7:0] d1 = 0, d2 = 0;
  logic       m_enter = 0, m_busy = 0;
  logic [7:0] m_data = 0, m_count = 0;

  task automatic model_reset();
    ph = M_ARMED; ones = 0; zeros = 0; hold_left = 0;
    e1 = 0; e2 = 0; d1 = 0; d2 = 0;
    m_enter = 0; m_busy = 0; m_data = 0; m_count = 0;
  endtask

  task automatic model_step();
    case (ph)
      M_ARMED: begin
        ones = e2 ? ones + 1 : 0;
        if (ones == D + 1) begin
          ph = M_HOLDING; hold_left = H;
          m_enter = 1; m_data = d2; m_count = m_count + 8'd1;
        end
      end
      M_HOLDING: begin
        hold_left--;
        if (hold_left == 0) begin ph = M_RELEASING; zeros = 0; m_enter = 0; end
      end
      default: begin
        zeros = e2 ? 0 : zeros + 1;
        if (zeros == D + 1) begin ph = M_ARMED; ones = 0; end
      end
    endcase
    m_busy = !(ph == M_ARMED && ones == 0);
    e2 = e1; d2 = d1; e1 = EnterIn; d1 = DataIn;
  endtask

  // Advance one clock: model samples at the rising edge, bench resumes at the falling edge.
  task automatic tick();
    @(posedge Clock);
    if (Reset) model_reset(); else model_step();
    @(negedge Clock);
  endtask

  task automatic do_reset();
    EnterIn = 0; DataIn = 0; Reset = 1;
    model_reset();
    tick(); tick();
    Reset = 0;
  endtask

  task automatic test_reset();
    DataIn = 8'h5A; EnterIn = 1; Reset = 1;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if ({DataOut, EnterOut, Busy, PressCount} !== 18'h0) begin
        errors++;
        $display("FAIL reset_hold got D=%h E=%b B=%b P=%0d exp all zero", DataOut, EnterOut, Busy, PressCount);
      end
    end
    Reset = 0; EnterIn = 0; DataIn = 0;
    tick();
    checks++;
    if ({DataOut, EnterOut, Busy, PressCount} !== 18'h0) begin
      errors++;
      $display("FAIL reset_release got D=%h E=%b B=%b P=%0d exp all zero", DataOut, EnterOut, Busy, PressCount);
    end
  endtask

  task automatic test_clean_press();
    int rise = -1, fall = -1, idle = -1;
    do_reset();
    DataIn = 8'hA5; EnterIn = 1;
    for (int k = 0; k < 60; k++) begin
      if (k == 40) EnterIn = 0;
      tick();
      checks++;
      if ({EnterOut, Busy, PressCount, DataOut} !== {m_enter, m_busy, m_count, m_data}) begin
        errors++;
        $display("FAIL clean_model k=%0d got %b%b/%0d/%h exp %b%b/%0d/%h", k, EnterOut, Busy,
                 PressCount, DataOut, m_enter, m_busy, m_count, m_data);
      end
      if (EnterOut && rise < 0) rise = k;
      if (!EnterOut && rise >= 0 && fall < 0) fall = k;
      if (k >= 40 && !Busy && idle < 0) idle = k;
    end
    checks++;
    if (rise != 2 + D) begin errors++; $display("FAIL clean_rise got edge %0d exp %0d", rise, 2 + D); end
    checks++;
    if (fall != 2 + D + H) begin errors++; $display("FAIL clean_fall got edge %0d exp %0d", fall, 2 + D + H); end
    checks++;
    if (idle != 40 + 2 + D) begin errors++; $display("FAIL clean_idle got edge %0d exp %0d", idle, 40 + 2 + D); end
    checks++;
    if (DataOut !== 8'hA5) begin errors++; $display("FAIL clean_data got %h exp a5", DataOut); end
    checks++;
    if (PressCount !== 8'd1) begin errors++; $display("FAIL clean_count got %0d exp 1", PressCount); end
  endtask

  task automatic test_bounce();
    bit saw = 0;
    do_reset();
    DataIn = 8'($urandom_range(1, 255));
    for (int k = 0; k < 24; k++) begin
      EnterIn = (k < 9) && (k % 3 != 2);
      tick();
      if (EnterOut) saw = 1;
      checks++;
      if ({EnterOut, Busy, PressCount, DataOut} !== {m_enter, m_busy, m_count, m_data}) begin
        errors++;
        $display("FAIL bounce_model k=%0d got %b%b/%0d/%h exp %b%b/%0d/%h", k, EnterOut, Busy,
                 PressCount, DataOut, m_enter, m_busy, m_count, m_data);
      end
    end
    checks++;
    if (saw) begin errors++; $display("FAIL bounce_enter got pulse exp none"); end
    checks++;
    if (PressCount !== 8'd0) begin errors++; $display("FAIL bounce_count got %0d exp 0", PressCount); end
    checks++;
    if (DataOut !== 8'h00) begin errors++; $display("FAIL bounce_data got %h exp 00", DataOut); end
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL bounce_busy got %b exp 0", Busy); end
  endtask

  task automatic test_data_isolation();
    do_reset();
    DataIn = 8'h3C; EnterIn = 1;
    repeat (D + 3) tick();
    DataIn = 8'hFF;
    for (int k = 0; k < 25; k++) begin
      tick();
      checks++;
      if (DataOut !== 8'h3C) begin errors++; $display("FAIL iso_hold k=%0d got %h exp 3c", k, DataOut); end
    end
    EnterIn = 0;
    repeat (D + 5) tick();
    checks++;
    if (Busy !== 1'b0 || DataOut !== 8'h3C) begin
      errors++;
      $display("FAIL iso_idle got B=%b D=%h exp B=0 D=3c", Busy, DataOut);
    end
    EnterIn = 1;
    repeat (D + 3) tick();
    checks++;
    if (DataOut !== 8'hFF || PressCount !== 8'd2) begin
      errors++;
      $display("FAIL iso_second got D=%h P=%0d exp D=ff P=2", DataOut, PressCount);
    end
  endtask

  task automatic test_held_switch();
    int hi = 0, pulses = 0;
    logic prev = 0;
    do_reset();
    DataIn = 8'($urandom); EnterIn = 1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (EnterOut) hi++;
      if (EnterOut && !prev) pulses++;
      prev = EnterOut;
    end
    checks++;
    if (hi != H) begin errors++; $display("FAIL held_width got %0d exp %0d", hi, H); end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL held_pulses got %0d exp 1", pulses); end
    EnterIn = 0;
    repeat (2) tick();
    EnterIn = 1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (EnterOut) pulses++;
      checks++;
      if ({EnterOut, Busy, PressCount} !== {m_enter, m_busy, m_count}) begin
        errors++;
        $display("FAIL held_model k=%0d got %b%b/%0d exp %b%b/%0d", k, EnterOut, Busy, PressCount,
                 m_enter, m_busy, m_count);
      end
    end
    checks++;
    if (pulses != 0 || PressCount !== 8'd1) begin
      errors++;
      $display("FAIL held_repress got pulses=%0d P=%0d exp pulses=0 P=1", pulses, PressCount);
    end
    checks++;
    if (Busy !== 1'b1) begin errors++; $display("FAIL held_busy got %b exp 1", Busy); end
    EnterIn = 0;
    repeat (20) tick();
  endtask

  task automatic test_async_reset();
    int rise = -1;
    do_reset();
    DataIn = 8'($urandom_range(1, 255)); EnterIn = 1;
    repeat (11) tick();
    checks++;
    if (EnterOut !== 1'b1) begin errors++; $display("FAIL areset_pre got E=%b exp 1", EnterOut); end
    #2 Reset = 1;
    model_reset();
    #1;
    checks++;
    if ({EnterOut, Busy, DataOut, PressCount} !== 18'h0) begin
      errors++;
      $display("FAIL areset_async got E=%b B=%b D=%h P=%0d exp all zero", EnterOut, Busy, DataOut, PressCount);
    end
    @(negedge Clock);
    Reset = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (EnterOut && rise < 0) rise = k;
    end
    checks++;
    if (rise != 2 + D) begin errors++; $display("FAIL areset_rise got edge %0d exp %0d", rise, 2 + D); end
    EnterIn = 0;
    repeat (D + 6) tick();
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    do_reset();
    for (int p = 0; p < 256; p++) begin
      v = 8'($urandom);
      DataIn = v; EnterIn = 1;
      repeat (D + H + 4) tick();
      EnterIn = 0;
      repeat (D + 4) tick();
      checks++;
      if (PressCount !== 8'(p + 1) || DataOut !== v) begin
        errors++;
        $display("FAIL wrap_press p=%0d got P=%0d D=%h exp P=%0d D=%h", p, PressCount, DataOut, 8'(p + 1), v);
      end
    end
    checks++;
    if (PressCount !== 8'd0) begin errors++; $display("FAIL wrap_final got %0d exp 0", PressCount); end
  endtask

  task automatic test_random();
    int len;
    do_reset();
    for (int s = 0; s < 150; s++) begin
      EnterIn = ~EnterIn;
      len = $urandom_range(1, 3 * D + H);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) DataIn = 8'($urandom);
        tick();
        checks++;
        if ({EnterOut, Busy, PressCount, DataOut} !== {m_enter, m_busy, m_count, m_data}) begin
          errors++;
          $display("FAIL random_model s=%0d got %b%b/%0d/%h exp %b%b/%0d/%h", s, EnterOut, Busy,
                   PressCount, DataOut, m_enter, m_busy, m_count, m_data);
        end
      end
    end
  endtask

  initial begin
    @(negedge Clock);
    test_reset();
    test_clean_press();
    test_bounce();
    test_data_isolation();
    test_held_switch();
    test_async_reset();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
